// File: rtl/conv_window_sequencer_pkg.sv
// conv_window_sequencer_pkg
//   Shared definitions for the 3x3 window sequencer.
//   Contents: the FSM state encoding, pixel width and kernel size, the Sobel
//   (vertical gradient) kernel constants, and helpers that split a tap index
//   k (0..8) into its window row and column.
package conv_window_sequencer_pkg;

   localparam int PIX_W = 8;
   localparam int KSIZE = 3;
   localparam int NTAPS = KSIZE * KSIZE;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FEED,
      ST_DRAIN,
      ST_WAIT,
      ST_CAPTURE,
      ST_OUT,
      ST_CLEAR,
      ST_DONE
   } state_e;

   // Vertical Sobel kernel, row-major (top row positive, bottom row negative).
   localparam int SOBEL_K [NTAPS] = '{1, 2, 1, 0, 0, 0, -1, -2, -1};

   function automatic logic [1:0] tap_row(input logic [3:0] k);
      if (k < 4'd3)      return 2'd0;
      else if (k < 4'd6) return 2'd1;
      else               return 2'd2;
   endfunction

   function automatic logic [1:0] tap_col(input logic [3:0] k);
      case (k)
         4'd0, 4'd3, 4'd6: return 2'd0;
         4'd1, 4'd4, 4'd7: return 2'd1;
         default:          return 2'd2;
      endcase
   endfunction

endpackage

// File: rtl/conv_window_sequencer_if.sv
// conv_window_sequencer_if
//   Bundles the sequencer's control, pixel-input, conv-datapath and result
//   signals.
//   Modports:
//     master - the sequencer (drives busy/done, pix_in_ready, conv_*, res_*).
//     slave  - the environment (drives start, pix_in*, conv_out, res_ready).
interface conv_window_sequencer_if #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   logic          start;
   logic          busy;
   logic          done;
   logic [7:0]    pix_in;
   logic          pix_in_valid;
   logic          pix_in_ready;
   logic          conv_data_in;
   logic [7:0]    conv_data;
   logic [1:0]    conv_row_in;
   logic [1:0]    conv_col_in;
   logic          conv_reset;
   logic [7:0]    conv_out;
   logic [7:0]    res_data;
   logic [XW-1:0] res_x;
   logic [YW-1:0] res_y;
   logic          res_valid;
   logic          res_ready;

   modport master (
      input  start, pix_in, pix_in_valid, conv_out, res_ready,
      output busy, done, pix_in_ready, conv_data_in, conv_data,
             conv_row_in, conv_col_in, conv_reset,
             res_data, res_x, res_y, res_valid
   );

   modport slave (
      output start, pix_in, pix_in_valid, conv_out, res_ready,
      input  busy, done, pix_in_ready, conv_data_in, conv_data,
             conv_row_in, conv_col_in, conv_reset,
             res_data, res_x, res_y, res_valid
   );

endinterface

// File: rtl/conv_window_sequencer_frame_ram.sv
// conv_window_sequencer_frame_ram
//   Single-port frame buffer, synchronous read with one cycle of latency.
//   Ports: clk, we (write enable), re (read enable), addr, wdata, rdata.
module conv_window_sequencer_frame_ram #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH),
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata     <= mem[addr];
   end

endmodule

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer
//   Captures one raster frame, walks every 3x3 window, feeds the 9 taps of
//   each window into the external conv accumulator, captures its clamped
//   result and streams results out in raster order (valid/ready).
//   Ports:
//     clk   - system clock, rising edge
//     reset - synchronous, active-high
//     bus   - conv_window_sequencer_if.master (start/busy/done, pixel input,
//             conv strobes and result stream)
//   Build option: BORDER_ZERO_EN - when defined, a window is centred on every
//   pixel and out-of-frame taps are fed as zero without a memory read.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start
//   LOAD    | accepting raster pixels into the frame buffer
//   FEED    | issuing the 9 tap reads of the current window (k = 0..8)
//   DRAIN   | last tap on conv_data
//   WAIT    | conv result settling
//   CAPTURE | register conv_out and window coordinates into res_*
//   OUT     | res_valid high, held until res_ready
//   CLEAR   | conv_reset pulse, advance to next window
//   DONE    | one-cycle done pulse
module conv_window_sequencer
   import conv_window_sequencer_pkg::*;
#(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   conv_window_sequencer_if.master  bus
);

   localparam int XW    = $clog2(IMG_W);
   localparam int YW    = $clog2(IMG_H);
   localparam int DEPTH = IMG_W * IMG_H;
   localparam int AW    = $clog2(DEPTH);
`ifdef BORDER_ZERO_EN
   localparam int X_LAST = IMG_W - 1;
   localparam int Y_LAST = IMG_H - 1;
`else
   localparam int X_LAST = IMG_W - 3;
   localparam int Y_LAST = IMG_H - 3;
`endif

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [3:0]    k_q, k_d;
   logic [7:0]    res_data_q, res_data_d;
   logic [XW-1:0] res_x_q, res_x_d;
   logic [YW-1:0] res_y_q, res_y_d;
   logic          res_valid_q, res_valid_d;

   logic          feed_q;
   logic          oob_q;
   logic [1:0]    row_q, col_q;
   logic          rst_pend_q;

   logic [1:0]    tap_r, tap_c;
   logic          tap_oob;
   int            ty, tx;
   logic [AW-1:0] rd_addr;

   logic          ram_we, ram_re;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_rdata;

   // Tap coordinates for the current k; in border mode (x,y) is the window
   // centre, otherwise it is the top-left corner.
   always_comb begin
      tap_r = tap_row(k_q);
      tap_c = tap_col(k_q);
`ifdef BORDER_ZERO_EN
      ty      = int'(y_q) + int'(tap_r) - 1;
      tx      = int'(x_q) + int'(tap_c) - 1;
      tap_oob = (ty < 0) || (ty >= IMG_H) || (tx < 0) || (tx >= IMG_W);
`else
      ty      = int'(y_q) + int'(tap_r);
      tx      = int'(x_q) + int'(tap_c);
      tap_oob = 1'b0;
`endif
      rd_addr = tap_oob ? '0 : AW'(ty * IMG_W + tx);
   end

   assign ram_we   = (state_q == ST_LOAD) && bus.pix_in_valid;
   assign ram_re   = (state_q == ST_FEED) && !tap_oob;
   assign ram_addr = (state_q == ST_LOAD) ? cnt_q : rd_addr;

   conv_window_sequencer_frame_ram #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (8)
   ) u_frame_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (bus.pix_in),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      x_d         = x_q;
      y_d         = y_q;
      k_d         = k_q;
      res_data_d  = res_data_q;
      res_x_d     = res_x_q;
      res_y_d     = res_y_q;
      res_valid_d = res_valid_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
            end
         end
         ST_LOAD: begin
            if (bus.pix_in_valid) begin
               cnt_d = cnt_q + AW'(1);
               if (cnt_q == AW'(DEPTH - 1)) begin
                  state_d = ST_FEED;
                  cnt_d   = '0;
                  x_d     = '0;
                  y_d     = '0;
                  k_d     = '0;
               end
            end
         end
         ST_FEED: begin
            k_d = k_q + 4'd1;
            if (k_q == 4'd8) begin
               k_d     = '0;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: state_d = ST_WAIT;
         ST_WAIT:  state_d = ST_CAPTURE;
         ST_CAPTURE: begin
            res_data_d  = bus.conv_out;
            res_x_d     = x_q;
            res_y_d     = y_q;
            res_valid_d = 1'b1;
            state_d     = ST_OUT;
         end
         ST_OUT: begin
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            k_d     = '0;
            state_d = ST_FEED;
            if (x_q == XW'(X_LAST)) begin
               x_d = '0;
               if (y_q == YW'(Y_LAST)) state_d = ST_DONE;
               else                    y_d     = y_q + YW'(1);
            end else begin
               x_d = x_q + XW'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         k_q         <= '0;
         res_data_q  <= '0;
         res_x_q     <= '0;
         res_y_q     <= '0;
         res_valid_q <= 1'b0;
         feed_q      <= 1'b0;
         oob_q       <= 1'b0;
         row_q       <= '0;
         col_q       <= '0;
         rst_pend_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         k_q         <= k_d;
         res_data_q  <= res_data_d;
         res_x_q     <= res_x_d;
         res_y_q     <= res_y_d;
         res_valid_q <= res_valid_d;
         // Tap tags are delayed one cycle to line up with the RAM read data.
         feed_q      <= (state_q == ST_FEED);
         oob_q       <= (state_q == ST_FEED) && tap_oob;
         row_q       <= (state_q == ST_FEED) ? tap_r : 2'd0;
         col_q       <= (state_q == ST_FEED) ? tap_c : 2'd0;
         rst_pend_q  <= 1'b0;
      end
   end

   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.done         = (state_q == ST_DONE);
   assign bus.pix_in_ready = (state_q == ST_LOAD);
   assign bus.conv_data_in = feed_q;
   assign bus.conv_data    = (feed_q && !oob_q) ? ram_rdata : 8'd0;
   assign bus.conv_row_in  = row_q;
   assign bus.conv_col_in  = col_q;
   // Held high for the cycle after reset so the accumulator starts clean.
   assign bus.conv_reset   = (state_q == ST_CLEAR) || rst_pend_q;
   assign bus.res_data     = res_data_q;
   assign bus.res_x        = res_x_q;
   assign bus.res_y        = res_y_q;
   assign bus.res_valid    = res_valid_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb_conv_window_sequencer
//   Drives whole frames into conv_window_sequencer, emulates the Sobel
//   accumulate-and-clamp conv unit, and checks every result, every conv
//   beat and the done/conv_reset pulses against a frame-level model.
//   Honours BORDER_ZERO_EN the same way as the design.
module tb_conv_window_sequencer;
   import conv_window_sequencer_pkg::*;

   localparam int W = 4;
   localparam int H = 4;
`ifdef BORDER_ZERO_EN
   localparam int OUT_W = W;
   localparam int OUT_H = H;
`else
   localparam int OUT_W = W - 2;
   localparam int OUT_H = H - 2;
`endif
   localparam int NRES   = OUT_W * OUT_H;
   localparam int BUDGET = 4000;

   typedef struct {
      int d;
      int x;
      int y;
   } res_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   conv_window_sequencer_if #(.IMG_W(W), .IMG_H(H)) bus();

   conv_window_sequencer #(.IMG_W(W), .IMG_H(H)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   int   n_vec = 0;
   int   n_fail = 0;
   bit   chk_en = 0;
   int   beats = 0;
   int   popped = 0;
   int   resets = 0;
   int   done_cnt = 0;
   int   bp_mode = 0;
   int   stall_left = 0;
   int   acc = 0;
   int   frame [W*H];
   res_t exp_q [$];

   task automatic chk(input string nm, input int act, input int expv);
      n_vec++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
      end
   endtask

   function automatic int clamp8(input int v);
      if (v < 0)   return 0;
      if (v > 255) return 255;
      return v;
   endfunction

   function automatic int pix_at(input int r, input int c);
      if (r < 0 || r >= H || c < 0 || c >= W) return 0;
      return frame[r*W + c];
   endfunction

   // Pixel value that tap k of window number win must carry.
   function automatic int tap_val(input int win, input int k);
      int ox, oy;
      ox = win % OUT_W;
      oy = win / OUT_W;
`ifdef BORDER_ZERO_EN
      return pix_at(oy - 1 + k / 3, ox - 1 + k % 3);
`else
      return pix_at(oy + k / 3, ox + k % 3);
`endif
   endfunction

   function automatic void build_model();
      res_t r;
      int raw;
      exp_q.delete();
      for (int win = 0; win < NRES; win++) begin
         raw = 0;
         for (int k = 0; k < 9; k++) raw += SOBEL_K[k] * tap_val(win, k);
         r.d = clamp8(raw);
         r.x = win % OUT_W;
         r.y = win / OUT_W;
         exp_q.push_back(r);
      end
   endfunction

   // Emulated conv unit: accumulate on strobe, clear on conv_reset, and
   // present the clamped sum one cycle later.
   always @(posedge clk) begin
      if (bus.conv_reset)
         acc <= 0;
      else if (bus.conv_data_in)
         acc <= acc + SOBEL_K[int'(bus.conv_row_in)*3 + int'(bus.conv_col_in)] * int'(bus.conv_data);
      bus.conv_out <= 8'(clamp8(acc));
   end

   // Result sink with selectable back-pressure.
   initial begin
      bus.res_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bus.res_valid && stall_left > 0) begin
            bus.res_ready = 1'b0;
            stall_left--;
         end else if (bp_mode == 1) begin
            bus.res_ready = ($urandom % 2) == 1;
         end else begin
            bus.res_ready = 1'b1;
         end
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         if (bus.res_valid) begin
            if (exp_q.size() == 0) begin
               chk("res_unexpected", 1, 0);
            end else begin
               chk("res_data", int'(bus.res_data), exp_q[0].d);
               chk("res_x", int'(bus.res_x), exp_q[0].x);
               chk("res_y", int'(bus.res_y), exp_q[0].y);
               if (bus.res_ready) begin
                  void'(exp_q.pop_front());
                  popped++;
               end
            end
         end
         if (bus.conv_data_in) begin
            if (beats >= 9) begin
               chk("beat_extra", beats, 8);
            end else begin
               chk("conv_row_in", int'(bus.conv_row_in), beats / 3);
               chk("conv_col_in", int'(bus.conv_col_in), beats % 3);
               chk("conv_data", int'(bus.conv_data), tap_val(popped, beats));
            end
            beats++;
         end
         if (bus.conv_reset) begin
            chk("beats_per_window", beats, 9);
            beats = 0;
            resets++;
         end
         if (bus.done) begin
            done_cnt++;
            chk("done_after_last", exp_q.size(), 0);
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, int'(bus.busy), 0);
      chk({tag, "_done"}, int'(bus.done), 0);
      chk({tag, "_pix_in_ready"}, int'(bus.pix_in_ready), 0);
      chk({tag, "_conv_data_in"}, int'(bus.conv_data_in), 0);
      chk({tag, "_conv_data"}, int'(bus.conv_data), 0);
      chk({tag, "_conv_row_in"}, int'(bus.conv_row_in), 0);
      chk({tag, "_conv_col_in"}, int'(bus.conv_col_in), 0);
      chk({tag, "_conv_reset"}, int'(bus.conv_reset), 1);
      chk({tag, "_res_data"}, int'(bus.res_data), 0);
      chk({tag, "_res_x"}, int'(bus.res_x), 0);
      chk({tag, "_res_y"}, int'(bus.res_y), 0);
      chk({tag, "_res_valid"}, int'(bus.res_valid), 0);
   endtask

   task automatic fill_frame(input int pat);
      for (int i = 0; i < W*H; i++) begin
         case (pat)
            0:       frame[i] = W*H - 1 - i;
            1:       frame[i] = 100;
            2:       frame[i] = (i < W) ? 255 : 0;
            3:       frame[i] = i;
            5:       frame[i] = 10;
            default: frame[i] = int'($urandom_range(0, 255));
         endcase
      end
   endtask

   // Hand-computed values that pin the model itself.
   task automatic pin_model(input int pat);
`ifdef BORDER_ZERO_EN
      if (pat == 5) begin
         chk("pin_top_centre", exp_q[1].d, 0);
         chk("pin_mid_edge", exp_q[4].d, 0);
         chk("pin_inner", exp_q[5].d, 0);
         chk("pin_bot_corner_l", exp_q[12].d, 30);
         chk("pin_bot_edge", exp_q[13].d, 40);
         chk("pin_bot_corner_r", exp_q[15].d, 30);
         chk("pin_coord_x", exp_q[13].x, 1);
         chk("pin_coord_y", exp_q[13].y, 3);
      end
`else
      case (pat)
         0: begin
            for (int i = 0; i < NRES; i++) chk("pin_desc", exp_q[i].d, 32);
            chk("pin_coord_x", exp_q[1].x, 1);
            chk("pin_coord_y", exp_q[2].y, 1);
         end
         1: for (int i = 0; i < NRES; i++) chk("pin_const", exp_q[i].d, 0);
         2: begin
            chk("pin_sat0", exp_q[0].d, 255);
            chk("pin_sat1", exp_q[1].d, 255);
            chk("pin_sat2", exp_q[2].d, 0);
         end
         3: for (int i = 0; i < NRES; i++) chk("pin_ramp", exp_q[i].d, 0);
         default: ;
      endcase
`endif
   endtask

   task automatic run_frame(input int pat, input int bp, input int abort);
      int i, guard, c;
      fill_frame(pat);
      build_model();
      pin_model(pat);
      bp_mode    = bp;
      stall_left = (bp == 2) ? 10 : 0;
      popped     = 0;
      resets     = 0;
      done_cnt   = 0;
      beats      = 0;

      // Pixels offered while idle must be ignored.
      @(posedge clk); #1;
      bus.pix_in_valid = 1'b1;
      bus.pix_in       = 8'hAA;
      repeat (2) @(posedge clk);
      #1;
      bus.pix_in_valid = 1'b0;
      bus.start        = 1'b1;
      @(posedge clk); #1;
      bus.start        = 1'b0;

      i = 0;
      guard = 0;
      while (i < W*H && guard < BUDGET) begin
         @(posedge clk); #1;
         bus.pix_in_valid = ($urandom % 4) != 0;
         bus.pix_in       = 8'(frame[i]);
         @(negedge clk);
         if (bus.pix_in_valid && bus.pix_in_ready) i++;
         guard++;
      end
      chk("load_complete", i, W*H);
      @(posedge clk); #1;
      bus.pix_in_valid = 1'b0;
      bus.start        = 1'b1;   // must be ignored while busy
      @(posedge clk); #1;
      bus.start        = 1'b0;

      if (abort >= 0) begin
         c = 0;
         while (!(popped == abort && beats >= 3) && c < BUDGET) begin
            @(negedge clk);
            c++;
         end
         chk("abort_reached", int'(c < BUDGET), 1);
         chk_en = 0;
         reset  = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check_reset_vals("abort_rst");
         reset = 1'b0;
         @(posedge clk);
         @(negedge clk);
         chk("abort_conv_reset_released", int'(bus.conv_reset), 0);
         chk("abort_no_result", int'(bus.res_valid), 0);
         exp_q.delete();
         beats  = 0;
         chk_en = 1;
         return;
      end

      c = 0;
      while (done_cnt == 0 && c < BUDGET) begin
         @(posedge clk);
         c++;
      end
      chk("frame_finished", int'(c < BUDGET), 1);
      chk("results_count", popped, NRES);
      chk("conv_reset_pulses", resets, NRES);
      @(negedge clk);
      chk("done_one_cycle", int'(bus.done), 0);
      chk("idle_after_done", int'(bus.busy), 0);
      repeat (3) @(posedge clk);
      chk("done_pulse_count", done_cnt, 1);
   endtask

   initial begin
      bus.start        = 1'b0;
      bus.pix_in       = 8'd0;
      bus.pix_in_valid = 1'b0;
      reset            = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_en = 1;

`ifdef BORDER_ZERO_EN
      run_frame(5, 0, -1);
`endif
      run_frame(0, 0, -1);
      run_frame(1, 0, -1);
      run_frame(2, 1, -1);
      run_frame(3, 0, -1);
      run_frame(0, 2, -1);
      run_frame(4, 1, -1);
      run_frame(4, 2, -1);
      run_frame(4, 0, 1);
      run_frame(4, 1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
